// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame parameters.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DEFAULT_OVS_FACTOR = 16;
   localparam int unsigned DEFAULT_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
`ifdef UART_RX_PARITY_EN
      ,
      PARITY
`endif
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1 by default) with a valid/ready holding register and status pulses.
// Defining UART_RX_PARITY_EN adds a parity bit, the PARITY_ODD parameter and parity_err.
module uart_rx
   import uart_pkg::*;
#(
`ifdef UART_RX_PARITY_EN
   parameter bit          PARITY_ODD = 1'b0,
`endif
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVS_FACTOR = DEFAULT_OVS_FACTOR
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick_16x,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int unsigned      OVS_W    = $clog2(OVS_FACTOR);
   localparam int unsigned      BIT_W    = $clog2(DATA_BITS + 1);
   localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS_FACTOR / 2 - 1);
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS_FACTOR - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   rx_state_e              state_q, state_d;
   logic [OVS_W-1:0]       ovs_cnt_q, ovs_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   rx_s;
`ifdef UART_RX_PARITY_EN
   logic                   parity_bit_q, parity_bit_d;
   logic                   parity_err_q, parity_err_d;
   logic                   parity_fail;

   // Data plus parity bit must XOR to PARITY_ODD.
   assign parity_fail = (^{shift_q, parity_bit_q}) ^ PARITY_ODD;
`endif

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      ovs_cnt_d   = ovs_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_d = parity_bit_q;
      parity_err_d = 1'b0;
`endif
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (tick_16x) begin
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d   = START;
                  ovs_cnt_d = '0;
               end
            end
            START: begin
               if (ovs_cnt_q == OVS_MID) begin
                  ovs_cnt_d = '0;
                  bit_cnt_d = '0;
                  state_d   = rx_s ? IDLE : DATA;
               end else begin
                  ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
               end
            end
            DATA: begin
               if (ovs_cnt_q == OVS_LAST) begin
                  ovs_cnt_d = '0;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end else begin
                  ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (ovs_cnt_q == OVS_LAST) begin
                  ovs_cnt_d    = '0;
                  parity_bit_d = rx_s;
                  state_d      = STOP;
               end else begin
                  ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
               end
            end
`endif
            STOP: begin
               if (ovs_cnt_q == OVS_LAST) begin
                  ovs_cnt_d = '0;
                  if (!rx_s) begin
                     frame_err_d = 1'b1;
                     state_d     = BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (parity_fail) begin
                     parity_err_d = 1'b1;
                     state_d      = IDLE;
`endif
                  end else begin
                     state_d = IDLE;
                     // A consume on this same cycle frees the register for the new byte.
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end
               end else begin
                  ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ovs_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ovs_cnt_q   <= ovs_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= parity_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
